prog_ctrl: RTL

//  Upstream front end of the clock divider. Turns three raw push-buttons into a

---
 rtl/prog_ctrl_pkg.sv | 25 ++
 rtl/prog_ctrl_debounce.sv | 51 +++++
 rtl/prog_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/prog_ctrl_pkg.sv
// Shared types and default timing constants for the divider programming front end.
package prog_ctrl_pkg;

  localparam int PROG_W_DEF          = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int TIMEOUT_CYCLES_DEF  = 250_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic set;
  } btn_press_t;

  // Counter width for a terminal count of n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_ctrl_debounce.sv
// Purpose: synchronise and debounce one raw button, emit a one-cycle press pulse.
// Latency: raw rise to press pulse = DEBOUNCE_CYCLES+3 cycles; release emits nothing.
// Backpressure: none, the pulse is fire-and-forget.
module btn_debounce
  import prog_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any sample matching the accepted level restarts the stability window.
      if (sync2 != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/prog_ctrl.sv
// Purpose: turn up/down/set buttons into a committed speed code plus update strobe.
// Latency: prog and update change together one cycle after the second set press.
// Backpressure: none, the divider samples prog on the single update cycle.
module prog_ctrl
  import prog_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  parameter int PROG_W          = PROG_W_DEF,
  parameter int RESET_PROG      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_set,
  output logic [PROG_W-1:0] prog,
  output logic              update,
  output logic              editing,
  output logic [PROG_W-1:0] prog_edit
);

  localparam int                TW      = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]     TO_MAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PROG_W-1:0] RST_VAL = PROG_W'(RESET_PROG);

  btn_press_t        press;
  state_t            state;
  state_t            state_nxt;
  logic [PROG_W-1:0] prog_nxt;
  logic [PROG_W-1:0] prog_edit_nxt;
  logic [TW-1:0]     to_cnt;
  logic [TW-1:0]     to_cnt_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .press (press.up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .press (press.down)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_set),
    .press (press.set)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      prog      <= RST_VAL;
      prog_edit <= RST_VAL;
      to_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      prog      <= prog_nxt;
      prog_edit <= prog_edit_nxt;
      to_cnt    <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    prog_nxt      = prog;
    prog_edit_nxt = prog_edit;
    to_cnt_nxt    = '0;
    editing       = 1'b0;
    update        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press.set) begin
          state_nxt     = ST_EDIT;
          prog_edit_nxt = prog;
        end
      end
      ST_EDIT: begin
        editing = 1'b1;
        // prog is loaded on entry to COMMIT so it is already stable while update is high.
        if (press.set) begin
          state_nxt = ST_COMMIT;
          prog_nxt  = prog_edit;
        end else begin
          if (press.up && !press.down) begin
            prog_edit_nxt = prog_edit + PROG_W'(1);
          end else if (press.down && !press.up) begin
            prog_edit_nxt = prog_edit - PROG_W'(1);
          end
          if (press.up || press.down) begin
            to_cnt_nxt = '0;
          end else if (to_cnt == TO_MAX) begin
            state_nxt     = ST_IDLE;
            prog_edit_nxt = prog;
          end else begin
            to_cnt_nxt = to_cnt + TW'(1);
          end
        end
      end
      ST_COMMIT: begin
        update    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
